// File: rtl/pipe_controller.sv
// pipe_controller: ID-stage control for a 5-stage pipeline.
// Decodes the ID instruction into the registered ex_* control bundle, detects
// load-use hazards, and runs a small FSM that serialises multi-cycle MULs and
// drains the pipe on HALT.
// Ports:
//   clk, reset (async, active-low)
//   instr_valid, opcode, funct7, rs1, rs2   ID-stage instruction
//   id_ex_rd, id_ex_memread                  instruction currently in EX
//   flush                                    kill the ID instruction
//   stall                                    combinational PC / IF-ID hold
//   ex_*                                     registered EX control bundle
//   halted, state                            FSM status
module pipe_controller #(
  parameter int DRAIN_CYCLES = 3,   // 1..15
  parameter int MUL_LATENCY  = 4,   // 2..15
  parameter bit ENABLE_MUL   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  input  logic [6:0] opcode,
  input  logic [6:0] funct7,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] id_ex_rd,
  input  logic       id_ex_memread,
  input  logic       flush,
  output logic       stall,
  output logic       ex_valid,
  output logic       ex_alusrc,
  output logic [1:0] ex_memtoreg,
  output logic       ex_regwrite,
  output logic       ex_memread,
  output logic       ex_memwrite,
  output logic [2:0] ex_aluop,
  output logic       ex_branch,
  output logic       ex_jal_sel,
  output logic       ex_jalr_sel,
  output logic       halted,
  output logic [1:0] state
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_HALT  = 7'b1111111;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MUL_WAIT = 2'b01,
    DRAIN    = 2'b10,
    HALTED   = 2'b11
  } state_e;

  typedef struct packed {
    logic       valid;
    logic       alusrc;
    logic [1:0] memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic [2:0] aluop;
    logic       branch;
    logic       jal_sel;
    logic       jalr_sel;
  } ctrl_t;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  ctrl_t      ex_q, ex_d, dec;
  logic       halted_q, halted_d;
  logic       is_mul, is_halt, load_use;

  // Instruction decode; dec.valid follows instr_valid for every opcode.
  always_comb begin
    dec     = '0;
    is_mul  = 1'b0;
    is_halt = 1'b0;
    case (opcode)
      OP_R: begin
        dec.regwrite = 1'b1;
        dec.aluop    = 3'b010;
        if (ENABLE_MUL && funct7 == 7'b0000001) begin
          dec.aluop = 3'b101;
          is_mul    = 1'b1;
        end
      end
      OP_I: begin
        dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.aluop = 3'b011;
      end
      OP_LOAD: begin
        dec.alusrc = 1'b1; dec.memtoreg = 2'b01; dec.regwrite = 1'b1;
        dec.memread = 1'b1;
      end
      OP_STORE: begin
        dec.alusrc = 1'b1; dec.memwrite = 1'b1;
      end
      OP_BR: begin
        dec.branch = 1'b1; dec.aluop = 3'b001;
      end
      OP_JAL: begin
        dec.alusrc = 1'b1; dec.memtoreg = 2'b10; dec.regwrite = 1'b1;
        dec.jal_sel = 1'b1; dec.aluop = 3'b100;
      end
      OP_JALR: begin
        dec.alusrc = 1'b1; dec.memtoreg = 2'b10; dec.regwrite = 1'b1;
        dec.jalr_sel = 1'b1;
      end
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
    dec.valid = instr_valid;
  end

  // rs2 is compared even for opcodes that do not read it: a spurious
  // stall costs one cycle, a missed one corrupts data.
  assign load_use = id_ex_memread && (id_ex_rd != 5'd0) &&
                    ((id_ex_rd == rs1) || (id_ex_rd == rs2)) && instr_valid;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      ex_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ex_q     <= ex_d;
      halted_q <= halted_d;
    end
  end

  // Next-state logic. Flush only matters in RUN: in MUL_WAIT/DRAIN the
  // older MUL/HALT must complete regardless.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (instr_valid && !flush) begin
          if (is_halt) begin
            state_d = DRAIN;
            cnt_d   = 4'(DRAIN_CYCLES);
          end else if (is_mul) begin
            state_d = MUL_WAIT;
            cnt_d   = 4'(MUL_LATENCY - 1);
          end
        end
      end
      MUL_WAIT, DRAIN: begin
        if (cnt_q <= 4'd1) begin
          state_d = (state_q == MUL_WAIT) ? RUN : HALTED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: ;   // HALTED is left only by reset
    endcase
  end

  // Output logic: priority flush > HALT > MUL > load-use in RUN; every
  // other state holds the front end and issues bubbles.
  always_comb begin
    stall    = 1'b0;
    ex_d     = '0;
    halted_d = (state_d == HALTED);
    if (state_q == RUN) begin
      if (!instr_valid || flush || is_halt) begin
        ex_d = '0;
      end else if (is_mul) begin
        ex_d = dec;
      end else if (load_use) begin
        stall = 1'b1;
      end else begin
        ex_d = dec;
      end
    end else begin
      stall = 1'b1;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_alusrc   = ex_q.alusrc;
  assign ex_memtoreg = ex_q.memtoreg;
  assign ex_regwrite = ex_q.regwrite;
  assign ex_memread  = ex_q.memread;
  assign ex_memwrite = ex_q.memwrite;
  assign ex_aluop    = ex_q.aluop;
  assign ex_branch   = ex_q.branch;
  assign ex_jal_sel  = ex_q.jal_sel;
  assign ex_jalr_sel = ex_q.jalr_sel;
  assign halted      = halted_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pipe_controller.sv
// Directed bench for pipe_controller. Two instances share stimulus: u_dut
// (MUL enabled) and u_nomul (ENABLE_MUL=0). Expected EX-stage results are
// queued when an instruction is driven and compared one clock later.
module tb_pipe_controller;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_HALT  = 7'b1111111;
  localparam logic [6:0] OP_UNK   = 7'b1111011;
  localparam logic [6:0] F7_MUL   = 7'b0000001;

  // {valid, alusrc, memtoreg[1:0], regwrite, memread, memwrite, aluop[2:0], branch, jal, jalr}
  localparam logic [12:0] C_BUB   = 13'b0_0_00_0_0_0_000_0_0_0;
  localparam logic [12:0] C_ADD   = 13'b1_0_00_1_0_0_010_0_0_0;
  localparam logic [12:0] C_ADDI  = 13'b1_1_00_1_0_0_011_0_0_0;
  localparam logic [12:0] C_LOAD  = 13'b1_1_01_1_1_0_000_0_0_0;
  localparam logic [12:0] C_STORE = 13'b1_1_00_0_0_1_000_0_0_0;
  localparam logic [12:0] C_BR    = 13'b1_0_00_0_0_0_001_1_0_0;
  localparam logic [12:0] C_JAL   = 13'b1_1_10_1_0_0_100_0_1_0;
  localparam logic [12:0] C_JALR  = 13'b1_1_10_1_0_0_000_0_0_1;
  localparam logic [12:0] C_MUL   = 13'b1_0_00_1_0_0_101_0_0_0;
  localparam logic [12:0] C_UNK   = 13'b1_0_00_0_0_0_000_0_0_0;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       instr_valid = 1'b0;
  logic [6:0] opcode = '0, funct7 = '0;
  logic [4:0] rs1 = '0, rs2 = '0, id_ex_rd = '0;
  logic       id_ex_memread = 1'b0, flush = 1'b0;

  logic       stall, ex_valid, ex_alusrc, ex_regwrite, ex_memread, ex_memwrite;
  logic       ex_branch, ex_jal_sel, ex_jalr_sel, halted;
  logic [1:0] ex_memtoreg, state;
  logic [2:0] ex_aluop;

  logic       stall_n, ex_valid_n, ex_alusrc_n, ex_regwrite_n, ex_memread_n, ex_memwrite_n;
  logic       ex_branch_n, ex_jal_sel_n, ex_jalr_sel_n, halted_n;
  logic [1:0] ex_memtoreg_n, state_n;
  logic [2:0] ex_aluop_n;

  always #5 clk = ~clk;

  pipe_controller #(.DRAIN_CYCLES(3), .MUL_LATENCY(4), .ENABLE_MUL(1'b1)) u_dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode),
    .funct7(funct7), .rs1(rs1), .rs2(rs2), .id_ex_rd(id_ex_rd),
    .id_ex_memread(id_ex_memread), .flush(flush), .stall(stall),
    .ex_valid(ex_valid), .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_aluop(ex_aluop), .ex_branch(ex_branch), .ex_jal_sel(ex_jal_sel),
    .ex_jalr_sel(ex_jalr_sel), .halted(halted), .state(state)
  );

  pipe_controller #(.DRAIN_CYCLES(3), .MUL_LATENCY(4), .ENABLE_MUL(1'b0)) u_nomul (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode),
    .funct7(funct7), .rs1(rs1), .rs2(rs2), .id_ex_rd(id_ex_rd),
    .id_ex_memread(id_ex_memread), .flush(flush), .stall(stall_n),
    .ex_valid(ex_valid_n), .ex_alusrc(ex_alusrc_n), .ex_memtoreg(ex_memtoreg_n),
    .ex_regwrite(ex_regwrite_n), .ex_memread(ex_memread_n), .ex_memwrite(ex_memwrite_n),
    .ex_aluop(ex_aluop_n), .ex_branch(ex_branch_n), .ex_jal_sel(ex_jal_sel_n),
    .ex_jalr_sel(ex_jalr_sel_n), .halted(halted_n), .state(state_n)
  );

  logic [12:0] ex_vec, ex_vec_n;
  assign ex_vec   = {ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread,
                     ex_memwrite, ex_aluop, ex_branch, ex_jal_sel, ex_jalr_sel};
  assign ex_vec_n = {ex_valid_n, ex_alusrc_n, ex_memtoreg_n, ex_regwrite_n, ex_memread_n,
                     ex_memwrite_n, ex_aluop_n, ex_branch_n, ex_jal_sel_n, ex_jalr_sel_n};

  typedef struct {
    string       name;
    logic [12:0] ex;
    logic [1:0]  st;
    logic        hl;
    logic        chk_n;
    logic [12:0] ex_n;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [6:0] f7,
                       input logic [4:0] r1, input logic [4:0] r2, input logic fl);
    instr_valid = v; opcode = op; funct7 = f7; rs1 = r1; rs2 = r2; flush = fl;
  endtask

  // Called just after a rising edge with inputs already driven: checks the
  // combinational stall, queues the expected EX result, clocks once, then
  // pops and compares.
  task automatic step(input string name, input logic [12:0] ex_e, input logic [1:0] st_e,
                      input logic hl_e, input logic stall_e,
                      input logic chk_n = 1'b0, input logic [12:0] ex_n_e = '0,
                      input logic stall_n_e = 1'b0);
    exp_t e;
    #1;
    chk({name, ".stall"}, 16'(stall), 16'(stall_e));
    if (chk_n) chk({name, ".stall_nomul"}, 16'(stall_n), 16'(stall_n_e));
    sb.push_back('{name, ex_e, st_e, hl_e, chk_n, ex_n_e});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.name, ".ex"}, 16'(ex_vec), 16'(e.ex));
    chk({e.name, ".state"}, 16'(state), 16'(e.st));
    chk({e.name, ".halted"}, 16'(halted), 16'(e.hl));
    if (e.chk_n) chk({e.name, ".ex_nomul"}, 16'(ex_vec_n), 16'(e.ex_n));
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst.ex", 16'(ex_vec), 16'(C_BUB));
    chk("rst.state", 16'(state), 16'd0);
    chk("rst.halted", 16'(halted), 16'd0);
    chk("rst.stall", 16'(stall), 16'd0);
    @(negedge clk);
    reset = 1'b1;

    // Plain decode of each class
    drive(1, OP_R,     0, 1, 2, 0); step("add",   C_ADD,   2'b00, 0, 0);
    drive(1, OP_I,     0, 1, 2, 0); step("addi",  C_ADDI,  2'b00, 0, 0);
    drive(1, OP_STORE, 0, 1, 2, 0); step("store", C_STORE, 2'b00, 0, 0);
    drive(1, OP_BR,    0, 1, 2, 0); step("br",    C_BR,    2'b00, 0, 0);
    drive(1, OP_JALR,  0, 1, 2, 0); step("jalr",  C_JALR,  2'b00, 0, 0);
    drive(1, OP_UNK,   0, 1, 2, 0); step("unk",   C_UNK,   2'b00, 0, 0);
    drive(0, OP_R,     0, 1, 2, 0); step("novld", C_BUB,   2'b00, 0, 0);

    // Load-use: LOAD x5, then ADD reading x5 stalls one cycle
    drive(1, OP_LOAD, 0, 1, 2, 0); step("load", C_LOAD, 2'b00, 0, 0);
    id_ex_rd = 5'd5; id_ex_memread = 1'b1;
    drive(1, OP_R, 0, 5, 2, 0);    step("lu.rs1", C_BUB, 2'b00, 0, 1);
    id_ex_memread = 1'b0;
    step("lu.redec", C_ADD, 2'b00, 0, 0);
    id_ex_rd = 5'd7; id_ex_memread = 1'b1;
    drive(1, OP_R, 0, 3, 7, 0);    step("lu.rs2", C_BUB, 2'b00, 0, 1);
    id_ex_rd = 5'd0;
    drive(1, OP_R, 0, 0, 0, 0);    step("lu.x0", C_ADD, 2'b00, 0, 0);
    id_ex_memread = 1'b0;

    // Flush kills the ID instruction, including a MUL
    drive(1, OP_R, 0, 1, 2, 1);      step("fl.add", C_BUB, 2'b00, 0, 0);
    drive(1, OP_R, F7_MUL, 1, 2, 1); step("fl.mul", C_BUB, 2'b00, 0, 0);

    // MUL: one issue cycle, 3 cycles in MUL_WAIT (flush ignored), then RUN.
    // The ENABLE_MUL=0 instance sees a plain R-type.
    drive(1, OP_R, F7_MUL, 1, 2, 0);
    step("mul", C_MUL, 2'b01, 0, 0, 1, C_ADD, 0);
    drive(1, OP_R, 0, 1, 2, 1);
    step("mw1", C_BUB, 2'b01, 0, 1, 1, C_BUB, 0);
    drive(1, OP_R, 0, 1, 2, 0);
    step("mw2", C_BUB, 2'b01, 0, 1);
    step("mw3", C_BUB, 2'b00, 0, 1);
    step("mw.done", C_ADD, 2'b00, 0, 0);

    // Reset pulse in MUL_WAIT with counter=2
    drive(1, OP_R, F7_MUL, 1, 2, 0); step("mul2", C_MUL, 2'b01, 0, 0);
    drive(1, OP_R, 0, 1, 2, 0);      step("mw2.1", C_BUB, 2'b01, 0, 1);
    reset = 1'b0;
    #1;
    chk("arst.state", 16'(state), 16'd0);
    chk("arst.ex", 16'(ex_vec), 16'(C_BUB));
    chk("arst.halted", 16'(halted), 16'd0);
    chk("arst.stall", 16'(stall), 16'd0);
    #3;
    reset = 1'b1;
    @(posedge clk); #1;
    drive(1, OP_JAL, 0, 1, 2, 0);    step("jal", C_JAL, 2'b00, 0, 0);

    // HALT together with flush: no FSM action
    drive(1, OP_HALT, 0, 0, 0, 1);   step("halt.fl", C_BUB, 2'b00, 0, 0);
    drive(1, OP_R, 0, 1, 2, 0);      step("halt.fl.next", C_ADD, 2'b00, 0, 0);

    // HALT: 3 cycles of DRAIN (flush ignored), then HALTED for good
    drive(1, OP_HALT, 0, 0, 0, 0);   step("halt", C_BUB, 2'b10, 0, 0);
    drive(1, OP_R, 0, 1, 2, 1);      step("dr1", C_BUB, 2'b10, 0, 1);
    drive(1, OP_R, 0, 1, 2, 0);      step("dr2", C_BUB, 2'b10, 0, 1);
    step("dr3", C_BUB, 2'b11, 1, 1);
    for (int i = 0; i < 10; i++) begin
      drive(1, (i % 2 == 0) ? OP_R : OP_JAL, 0, 1, 2, (i % 3 == 0) ? 1'b1 : 1'b0);
      step("hlt", C_BUB, 2'b11, 1, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_controller.md
PIPE_CONTROLLER -- requirements
Module: pipe_controller

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 3: bubble cycles issued after HALT decode before halted asserts; legal range 1..15.
REQ-002 SHALL have parameter MUL_LATENCY, default 4: EX occupancy of a MUL, in cycles; legal range 2..15.
REQ-003 SHALL have parameter ENABLE_MUL, default 1: 1 = decode R-type with funct7=0000001 as MUL; 0 = decode it as plain R-type.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- instr_valid  in  1  ID-stage instruction valid
- opcode  in  7  ID instruction [6:0]
- funct7  in  7  ID instruction [31:25]
- rs1  in  5  ID source register 1
- rs2  in  5  ID source register 2
- id_ex_rd  in  5  destination register of the instruction now in EX
- id_ex_memread  in  1  instruction now in EX is a load
- flush  in  1  branch/jump taken in EX; kill the ID instruction
- stall  out  1  hold PC and IF/ID (combinational)
- ex_valid  out  1  registered: EX-stage slot holds a real instruction
- ex_alusrc  out  1  registered ALUSrc
- ex_memtoreg  out  2  registered MemtoReg
- ex_regwrite  out  1  registered RegWrite
- ex_memread  out  1  registered MemRead
- ex_memwrite  out  1  registered MemWrite
- ex_aluop  out  3  registered ALUOp
- ex_branch  out  1  registered Branch
- ex_jal_sel  out  1  registered Jal_Sel
- ex_jalr_sel  out  1  registered Jalr_Sel
- halted  out  1  registered: core halted
- state  out  2  FSM state (RUN=00, MUL_WAIT=01, DRAIN=10, HALTED=11)

Function
REQ-005 Decode SHALL be as follows (every control not listed = 0):
- R 0110011: regwrite, aluop=010; aluop=101 when MUL.
- I 0010011: alusrc, regwrite, aluop=011.
- LOAD 0000011: alusrc, memtoreg=01, regwrite, memread, aluop=000.
- STORE 0100011: alusrc, memwrite, aluop=000.
- BR 1100011: branch, aluop=001.
- JAL 1101111: alusrc, memtoreg=10, regwrite, jal_sel, aluop=100.
- JALR 1100111: alusrc, memtoreg=10, regwrite, jalr_sel, aluop=000.
- HALT 1111111: all controls 0; drives the FSM.
- Any other opcode: all controls 0, ex_valid=instr_valid.
REQ-006 A bubble SHALL be all ex_* outputs = 0, including ex_valid.
REQ-007 Load-use hazard = id_ex_memread & id_ex_rd!=0 & (id_ex_rd==rs1 | id_ex_rd==rs2) & instr_valid; rs2 is compared for every opcode (conservative).
REQ-008 Priority per cycle SHALL be flush > HALT > MUL > load-use.
REQ-009 In RUN, flush: the next EX slot is a bubble, stall=0, and the state stays RUN even if the ID instruction is HALT or MUL.
REQ-010 In RUN, load-use (no flush): stall=1, the next EX slot is a bubble, and the ID instruction is re-decoded the following cycle.
REQ-011 In RUN, valid MUL (no flush): the MUL is issued to EX and the state goes to MUL_WAIT with counter=MUL_LATENCY-1.
REQ-012 In MUL_WAIT: stall=1, bubbles issued, counter decrements each cycle; at counter==1 the next state is RUN.
REQ-013 In MUL_WAIT, flush SHALL be ignored, because an older MUL cannot be overtaken.
REQ-014 In RUN, valid HALT (no flush): a bubble is issued and the state goes to DRAIN with counter=DRAIN_CYCLES.
REQ-015 In DRAIN: stall=1, bubbles issued, flush ignored; at counter==1 the next state is HALTED.
REQ-016 In HALTED: halted=1, stall=1, bubbles only; the state is left only by reset.
REQ-017 With instr_valid=0 in RUN: a bubble is issued, stall=0, and no hazard or FSM action occurs.
REQ-018 Latency: decode to ex_* outputs SHALL be exactly one clock.

Reset
REQ-019 When reset=0, asynchronously: state=RUN, counters=0, all ex_* outputs=0, halted=0; stall is combinational and equals 0 in RUN with no hazard.
REQ-020 Reset asserted in any state (including mid-MUL_WAIT or mid-DRAIN) SHALL abort it fully; the first edge after deassertion decodes normally.

Verification
REQ-021 LOAD then ADD with rs1=id_ex_rd=5, id_ex_memread=1 -> stall=1 for one cycle, one bubble, then ex_aluop=010 and ex_regwrite=1.
REQ-022 MUL (funct7=0000001) with MUL_LATENCY=4 -> ex_aluop=101 for one cycle, then stall=1 and state=01 for 3 cycles, then RUN.
REQ-023 HALT with DRAIN_CYCLES=3 -> state=10 for 3 cycles, then state=11 and halted=1, with stall=1 held through 10 further cycles.
REQ-024 HALT and flush in the same cycle -> bubble issued, state stays 00, halted=0, stall=0.
REQ-025 Reset pulse during MUL_WAIT (counter=2) -> all outputs 0 immediately and state=00; a following JAL gives ex_memtoreg=10 and ex_jal_sel=1.
REQ-026 ENABLE_MUL=0 with the same MUL encoding -> ex_aluop=010 and no stall.
